// File: rtl/nor_sweep_checker.sv
// rtl/nor_sweep_checker.sv - drives a 2-input NOR through all four vectors and checks its output
module nor_sweep_checker #(
  parameter int SETTLE_CYCLES = 10,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ans,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_d, b_d;
  logic [2:0]       err_d;
  logic [3:0]       mask_d;
  logic             expected;

  // Vector index i maps to (a,b) = (i[0], i[1]); only vector 0 (00) yields a NOR output of 1.
  assign expected = (idx_q == 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      a         <= a_d;
      b         <= b_d;
      err_count <= err_d;
      fail_mask <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a;
    b_d     = b;
    err_d   = err_count;
    mask_d  = fail_mask;
    case (state_q)
      IDLE, DONE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          err_d   = 3'd0;
          mask_d  = 4'd0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (ans != expected) begin
          err_d         = err_count + 3'd1;
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          // Next vector goes out on the same edge that re-enters DRIVE.
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = DRIVE;
          a_d     = idx_d[0];
          b_d     = idx_d[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == DRIVE) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_nor_sweep_checker.sv
// tb/tb_nor_sweep_checker.sv - self-checking bench for nor_sweep_checker
module tb_nor_sweep_checker;

  localparam int S0 = 10;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n, start, start1;
  logic [3:0] tt, tt1;
  logic       ans, a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic       ans1, a1, b1, busy1, done1, pass1;
  logic [2:0] err_count1;
  logic [3:0] fail_mask1;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  // Gate under test: truth table indexed by {b,a}.
  assign ans  = tt[{b, a}];
  assign ans1 = tt1[{b1, a1}];

  nor_sweep_checker #(.SETTLE_CYCLES(S0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ans(ans), .a(a), .b(b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask)
  );

  nor_sweep_checker #(.SETTLE_CYCLES(S1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ans(ans1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .fail_mask(fail_mask1)
  );

  function automatic void ref_sweep(input logic [3:0] gate, output logic [3:0] mask, output int errs);
    mask = 4'd0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      logic va, vb, want, got;
      va   = (i == 1) || (i == 3);
      vb   = (i >= 2);
      want = !(va || vb);
      got  = gate[{vb, va}];
      if (got !== want) begin
        mask[i] = 1'b1;
        errs++;
      end
    end
  endfunction

  task automatic run_sweep(input logic [3:0] gate, input bit busy_pulses, input string name);
    logic [3:0] emask;
    int         eerr, seq_err, done_err, vi;
    logic       ea, eb;
    ref_sweep(gate, emask, eerr);
    seq_err  = 0;
    done_err = 0;
    tt = gate;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t <= 4 * (S0 + 1); t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (t < 4 * (S0 + 1)) begin
        vi = t / (S0 + 1);
        ea = (vi == 1) || (vi == 3);
        eb = (vi >= 2);
        if (a !== ea || b !== eb || busy !== 1'b1) seq_err++;
        if (done !== 1'b0) done_err++;
      end else begin
        if (done !== 1'b1 || busy !== 1'b0 || a !== 1'b0 || b !== 1'b0) done_err++;
      end
      start = busy_pulses && ((t + 2 == 5) || (t + 2 == 30));
    end
    start = 1'b0;
    tests++;
    if (seq_err !== 0) begin
      fails++;
      $display("FAIL %s ab_sequence: %0d bad cycles, required 0", name, seq_err);
    end
    tests++;
    if (done_err !== 0) begin
      fails++;
      $display("FAIL %s done_timing: %0d bad cycles, required 0 (done at edge 45)", name, done_err);
    end
    tests++;
    if (err_count !== 3'(eerr)) begin
      fails++;
      $display("FAIL %s err_count: got %0d, required %0d", name, err_count, eerr);
    end
    tests++;
    if (fail_mask !== emask) begin
      fails++;
      $display("FAIL %s fail_mask: got %b, required %b", name, fail_mask, emask);
    end
    tests++;
    if (pass !== (eerr == 0)) begin
      fails++;
      $display("FAIL %s pass: got %b, required %b", name, pass, (eerr == 0));
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b1;
    start1 = 1'b1;
    tt     = 4'b0001;
    tt1    = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({a, b, busy, done, pass, err_count, fail_mask} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {a, b, busy, done, pass, err_count, fail_mask});
    end
    tests++;
    if ({a1, b1, busy1, done1, pass1, err_count1, fail_mask1} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs_s1: got %b, required all zero",
               {a1, b1, busy1, done1, pass1, err_count1, fail_mask1});
    end
    start  = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mid_reset();
    tt = 4'b1110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    tests++;
    if (err_count !== 3'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL live_err_before_reset: got err=%0d busy=%b, required err=1 busy=1", err_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({a, b, busy, done, pass, err_count, fail_mask} !== 11'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b, required all zero",
               {a, b, busy, done, pass, err_count, fail_mask});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
    run_sweep(4'b0001, 1'b0, "after_reset");
  endtask

  task automatic test_held_start();
    int early;
    early = 0;
    tt1 = 4'b0001;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 2; e <= 9; e++) begin
      @(posedge clk);
      #1;
      if (e < 9 && done1 !== 1'b0) early++;
    end
    tests++;
    if (done1 !== 1'b1 || pass1 !== 1'b1 || err_count1 !== 3'd0 || early !== 0) begin
      fails++;
      $display("FAIL s1_first_sweep: got done=%b pass=%b err=%0d early=%0d, required 1 1 0 0",
               done1, pass1, err_count1, early);
    end
    tt1 = 4'b1111;
    @(posedge clk);
    #1;
    tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b1 || fail_mask1 !== 4'd0 || err_count1 !== 3'd0) begin
      fails++;
      $display("FAIL s1_restart: got done=%b busy=%b mask=%b err=%0d, required 0 1 0000 0",
               done1, busy1, fail_mask1, err_count1);
    end
    early = 0;
    for (int e = 11; e <= 18; e++) begin
      @(posedge clk);
      #1;
      if (e < 18 && done1 !== 1'b0) early++;
    end
    start1 = 1'b0;
    tests++;
    if (done1 !== 1'b1 || early !== 0) begin
      fails++;
      $display("FAIL s1_second_done: got done=%b early=%0d, required 1 0", done1, early);
    end
    tests++;
    if (fail_mask1 !== 4'b1110 || err_count1 !== 3'd3 || pass1 !== 1'b0) begin
      fails++;
      $display("FAIL s1_stuck1: got mask=%b err=%0d pass=%b, required 1110 3 0",
               fail_mask1, err_count1, pass1);
    end
  endtask

  task automatic test_random();
    logic [3:0] gate;
    for (int k = 0; k < 5; k++) begin
      gate = 4'($urandom_range(0, 15));
      run_sweep(gate, k[0], "random");
    end
  endtask

  initial begin
    test_reset();
    run_sweep(4'b0001, 1'b0, "ideal_nor");
    run_sweep(4'b0000, 1'b0, "stuck0");
    run_sweep(4'b1110, 1'b0, "or_gate");
    run_sweep(4'b0001, 1'b1, "start_while_busy");
    test_mid_reset();
    test_held_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
